// File: rtl/shared_ram_arbiter_pkg.sv
// shared_ram_pkg: shared types, defaults and helpers for the shared RAM arbiter
//   state_t        FSM states IDLE/RUN
//   DEF_*          default parameter values
//   CONF_CNT_W     contention counter width
//   onehot_to_idx  one-hot (up to 8 bits) to binary index
package shared_ram_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DEF_N_PORTS = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int CONF_CNT_W = 16;
  localparam int MAX_PORTS = 8;
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
    onehot_to_idx = '0;
    for (int i = 0; i < MAX_PORTS; i++) if (oh[i]) onehot_to_idx = onehot_to_idx | 3'(i);
  endfunction
endpackage

// File: rtl/shared_ram_arbiter_if.sv
// shared_ram_arbiter_if: per-port request bus between cores (master) and the shared RAM (slave)
//   req/we/addr/wdata  core -> RAM, packed per port
//   gnt/rvalid/rdata   RAM -> core
interface shared_ram_arbiter_if
  import shared_ram_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [N_PORTS-1:0] req, we, gnt, rvalid;
  logic [N_PORTS*ADDR_W-1:0] addr;
  logic [N_PORTS*DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/shared_ram_arbiter_rr.sv
// rr_arbiter: combinational round-robin picker
//   req  per-port requests; ptr  highest-priority port; en  arbitration enable
//   gnt  one-hot grant, zero when en is low or nothing requests
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);
  // Scan from farthest to nearest so the port closest to ptr overwrites the rest.
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (en && req[(int'(ptr) + i) % N]) gnt = N'(1) << ((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter: single-port RAM time-shared by N cores through a round-robin arbiter
//   clk, rst (async active-low), start (run enable), busy (in RUN)
//   bus (slave): req/we/addr/wdata in, gnt (combinational), rvalid/rdata (registered)
//   conf_cnt: contention counter, built only with SHARED_RAM_CONF_CNT_EN, else 0
module shared_ram_arbiter
  import shared_ram_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic [CONF_CNT_W-1:0] conf_cnt,
  shared_ram_arbiter_if.slave   bus
);
  localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  state_t state;
  logic [IW-1:0] ptr, gidx;
  logic [N_PORTS-1:0] gnt, rvalid;
  logic [DATA_W-1:0] rdata, g_wdata;
  logic [ADDR_W-1:0] g_addr;
  logic any_g, g_we;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  rr_arbiter #(.N(N_PORTS), .IW(IW)) u_arb (.req(bus.req), .ptr(ptr), .en(state == RUN), .gnt(gnt));
  always_comb begin
    any_g = |gnt;
    gidx = IW'(onehot_to_idx(MAX_PORTS'(gnt)));
    g_we = bus.we[gidx];
    g_addr = bus.addr[gidx*ADDR_W +: ADDR_W];
    g_wdata = bus.wdata[gidx*DATA_W +: DATA_W];
  end
  assign bus.gnt = gnt;
  assign bus.rvalid = rvalid;
  assign bus.rdata = rdata;
  always_ff @(posedge clk) if (any_g && g_we) mem[g_addr] <= g_wdata;
  // The FSM's next state is just start, so busy is registered from the same term.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      ptr <= '0;
      rvalid <= '0;
      rdata <= '0;
    end else begin
      state <= start ? RUN : IDLE;
      busy <= start;
      ptr <= any_g ? IW'((int'(gidx) + 1) % N_PORTS) : ptr;
      rvalid <= (any_g && !g_we) ? gnt : '0;
      rdata <= (any_g && !g_we) ? mem[g_addr] : rdata;
    end
  end
`ifdef SHARED_RAM_CONF_CNT_EN
  logic [CONF_CNT_W-1:0] cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else if (state == IDLE && start) cnt <= '0;
    else if (state == RUN && $countones(bus.req) >= 2 && cnt != '1) cnt <= cnt + CONF_CNT_W'(1);
  end
  assign conf_cnt = cnt;
`else
  assign conf_cnt = '0;
`endif
endmodule
